// File: rtl/ahb_types_pkg.sv
// rtl/ahb_types_pkg.sv - shared AHB widths, encodings and burst helpers
package ahb_types_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int HBURST_WIDTH = 3;

    // Beat countdown only needs to hold len-1 of the longest fixed burst (16).
    localparam int CNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        FIXED = 2'd1,
        INCR  = 2'd2
    } arb_state_e;

    // Beat count of a burst; SINGLE is one beat, INCR has no fixed length (0).
    function automatic logic [4:0] burst_len(input hburst_e b);
        logic [4:0] len;
        case (b)
            HB_SINGLE:           len = 5'd1;
            HB_WRAP4,  HB_INCR4:  len = 5'd4;
            HB_WRAP8,  HB_INCR8:  len = 5'd8;
            HB_WRAP16, HB_INCR16: len = 5'd16;
            default:             len = 5'd0;
        endcase
        return len;
    endfunction

    // True for the wrapping/incrementing bursts of known length.
    function automatic logic is_fixed_burst(input hburst_e b);
        return (b != HB_SINGLE) && (b != HB_INCR);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin pick after the last owner
module ahb_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan last+N down to last+1 so the nearest requester after last wins;
    // the last owner itself is the final candidate when nobody else asks.
    always_comb begin
        int c;
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        idx   = last;
        c     = 0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            c    = (int'(last) + k) % N;
            cand = IDX_W'(c);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB-Lite arbiter with burst-locked grant
module ahb_bus_arbiter
    import ahb_types_pkg::*;
#(
    parameter int N_MGR        = 4,
    parameter int ADDR_WIDTH   = ahb_types_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = ahb_types_pkg::DATA_WIDTH,
    parameter int HBURST_WIDTH = ahb_types_pkg::HBURST_WIDTH
) (
    input  logic                                   HCLK,
    input  logic                                   HRESETn,
    input  logic [N_MGR-1:0]                       m_req,
    input  logic [N_MGR-1:0][ADDR_WIDTH-1:0]       m_haddr,
    input  logic [N_MGR-1:0][1:0]                  m_htrans,
    input  logic [N_MGR-1:0]                       m_hwrite,
    input  logic [N_MGR-1:0][2:0]                  m_hsize,
    input  logic [N_MGR-1:0][HBURST_WIDTH-1:0]     m_hburst,
    input  logic [N_MGR-1:0][DATA_WIDTH-1:0]       m_hwdata,
    output logic [N_MGR-1:0]                       m_grant,
    output logic [$clog2(N_MGR)-1:0]               dp_owner,
    output logic                                   dp_valid,
    output logic [ADDR_WIDTH-1:0]                  HADDR,
    output logic [1:0]                             HTRANS,
    output logic                                   HWRITE,
    output logic [2:0]                             HSIZE,
    output logic [HBURST_WIDTH-1:0]                HBURST,
    output logic [DATA_WIDTH-1:0]                  HWDATA,
    input  logic                                   HREADY,
    input  logic                                   HRESP
);

    localparam int IDX_W = $clog2(N_MGR);

    arb_state_e             state_q, state_n;
    logic [N_MGR-1:0]       grant_q, grant_n;
    logic [IDX_W-1:0]       owner_q, owner_n;
    logic [IDX_W-1:0]       dp_owner_q, dp_owner_n;
    logic                   dp_valid_q, dp_valid_n;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_n;
    logic                   err_q, err_n;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   gnt_any;
    htrans_e                cur_trans;
    hburst_e                cur_burst;

    assign gnt_any   = |grant_q;
    assign cur_trans = htrans_e'(HTRANS);
    assign cur_burst = hburst_e'(HBURST);

    ahb_rr_picker #(
        .N     (N_MGR),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (m_req),
        .last  (owner_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State register: FSM, grant, burst countdown, error latch and data-phase owner.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ARB;
            grant_q    <= '0;
            owner_q    <= '0;
            dp_owner_q <= '0;
            dp_valid_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            grant_q    <= grant_n;
            owner_q    <= owner_n;
            dp_owner_q <= dp_owner_n;
            dp_valid_q <= dp_valid_n;
            cnt_q      <= cnt_n;
            err_q      <= err_n;
        end
    end

    // Next state: only an HREADY=1 cycle may move the grant, so a stalled
    // address phase is never handed to another manager.
    always_comb begin
        logic rearb;
        state_n    = state_q;
        grant_n    = grant_q;
        owner_n    = owner_q;
        dp_owner_n = dp_owner_q;
        dp_valid_n = dp_valid_q;
        cnt_n      = cnt_q;
        err_n      = err_q;
        rearb      = 1'b0;

        if (HREADY) begin
            dp_owner_n = owner_q;
            dp_valid_n = gnt_any && ((cur_trans == HT_NONSEQ) || (cur_trans == HT_SEQ));
            err_n      = 1'b0;

            if (err_q) begin
                // Second cycle of an error response: abandon whatever burst was running.
                state_n = ARB;
                cnt_n   = '0;
                rearb   = 1'b1;
            end else begin
                case (state_q)
                    ARB: begin
                        if (gnt_any && (cur_trans == HT_NONSEQ) && (cur_burst != HB_SINGLE)) begin
                            if (is_fixed_burst(cur_burst)) begin
                                state_n = FIXED;
                                cnt_n   = CNT_WIDTH'(burst_len(cur_burst) - 5'd1);
                            end else begin
                                state_n = INCR;
                                cnt_n   = '0;
                            end
                        end else begin
                            rearb = 1'b1;
                        end
                    end

                    FIXED: begin
                        case (cur_trans)
                            HT_SEQ: begin
                                if (cnt_q <= CNT_WIDTH'(1)) begin
                                    state_n = ARB;
                                    cnt_n   = '0;
                                    rearb   = 1'b1;
                                end else begin
                                    cnt_n = cnt_q - CNT_WIDTH'(1);
                                end
                            end
                            HT_BUSY: begin
                                cnt_n = cnt_q;
                            end
                            HT_NONSEQ: begin
                                // A new burst started before the old one finished.
                                if (is_fixed_burst(cur_burst)) begin
                                    cnt_n = CNT_WIDTH'(burst_len(cur_burst) - 5'd1);
                                end else if (cur_burst == HB_INCR) begin
                                    state_n = INCR;
                                    cnt_n   = '0;
                                end else begin
                                    state_n = ARB;
                                    cnt_n   = '0;
                                    rearb   = 1'b1;
                                end
                            end
                            default: begin
                                state_n = ARB;
                                cnt_n   = '0;
                                rearb   = 1'b1;
                            end
                        endcase
                    end

                    INCR: begin
                        if (!m_req[owner_q] || (cur_trans == HT_IDLE) || (cur_trans == HT_NONSEQ)) begin
                            state_n = ARB;
                            rearb   = 1'b1;
                        end
                    end

                    default: begin
                        state_n = ARB;
                        cnt_n   = '0;
                        rearb   = 1'b1;
                    end
                endcase
            end

            if (rearb) begin
                grant_n = '0;
                if (pick_valid) begin
                    grant_n[pick_idx] = 1'b1;
                    owner_n           = pick_idx;
                end
            end
        end else if (HRESP) begin
            // First error cycle: note it now, act on the following HREADY=1.
            err_n = 1'b1;
            cnt_n = '0;
        end
    end

    // Output mux: owner's address phase onto the bus, data-phase owner's HWDATA.
    always_comb begin
        HADDR  = '0;
        HTRANS = HT_IDLE;
        HWRITE = 1'b0;
        HSIZE  = '0;
        HBURST = '0;
        HWDATA = '0;
        if (gnt_any) begin
            HADDR  = m_haddr[owner_q];
            HTRANS = m_htrans[owner_q];
            HWRITE = m_hwrite[owner_q];
            HSIZE  = m_hsize[owner_q];
            HBURST = m_hburst[owner_q];
        end
        if (dp_valid_q) begin
            HWDATA = m_hwdata[dp_owner_q];
        end
    end

    assign m_grant  = grant_q;
    assign dp_owner = dp_owner_q;
    assign dp_valid = dp_valid_q;

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Single-layer AHB arbiter that shares one AHB-Lite bus between N_MGR managers.
- Grants the address phase round-robin and holds the grant for the full length of fixed-length and undefined-length (INCR) bursts.
- Muxes the owner's address-phase signals onto the shared bus.
- Muxes HWDATA from the data-phase owner.
- Sits between the manager agents/masters and the decoder/subordinate mux that produces HREADYOUT/HRESP.

Parameters:
N_MGR, 4, number of managers (2..8)
ADDR_WIDTH, ahb_types_pkg::ADDR_WIDTH, address width
DATA_WIDTH, ahb_types_pkg::DATA_WIDTH, data width
HBURST_WIDTH, ahb_types_pkg::HBURST_WIDTH, burst field width (3)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
m_req  in  N_MGR  bus request per manager
m_haddr  in  N_MGR x ADDR_WIDTH  manager addresses
m_htrans  in  N_MGR x 2  manager HTRANS
m_hwrite  in  N_MGR  manager HWRITE
m_hsize  in  N_MGR x 3  manager HSIZE
m_hburst  in  N_MGR x HBURST_WIDTH  manager HBURST
m_hwdata  in  N_MGR x DATA_WIDTH  manager write data
m_grant  out  N_MGR  one-hot address-phase grant, registered
dp_owner  out  $clog2(N_MGR)  index of the current data-phase owner
dp_valid  out  1  data phase holds a real (NONSEQ/SEQ) transfer
HADDR  out  ADDR_WIDTH  shared bus address
HTRANS  out  2  shared bus HTRANS
HWRITE  out  1  shared bus HWRITE
HSIZE  out  3  shared bus HSIZE
HBURST  out  HBURST_WIDTH  shared bus HBURST
HWDATA  out  DATA_WIDTH  shared bus write data
HREADY  in  1  HREADYOUT from the subordinate mux
HRESP  in  1  response from the subordinate mux

Behaviour:
Encodings:
- HTRANS: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HBURST: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.

Reset (asynchronous, HRESETn=0):
- m_grant=0, owner index=0, dp_owner=0, dp_valid=0.
- beat counter=0, FSM=ARB.
- Bus outputs: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0.
- Reset mid-burst abandons the burst with no completion.

Address mux:
- With owner g granted, HADDR/HTRANS/HWRITE/HSIZE/HBURST = m_*[g] (combinational).
- With no grant, HTRANS=IDLE and all other address outputs are 0.

FSM states ARB, FIXED, INCR:
- State and grant update only on a cycle with HREADY=1. With HREADY=0, everything holds.
- ARB:
  - Next owner is the first requesting index after the last owner (round-robin); if none request, m_grant=0.
  - The grant becomes visible the next cycle, so the new owner's first address phase is one cycle after arbitration.
  - If the current owner issues NONSEQ with a fixed burst (codes 2..7) and HREADY=1: load counter=len-1 (len 4/8/16) and go to FIXED.
  - If it issues NONSEQ with INCR: go to INCR.
  - SINGLE keeps ARB.
- FIXED:
  - Grant held.
  - SEQ with HREADY=1 decrements the counter; BUSY does not.
  - When the counter reaches 0 on an accepted SEQ, go to ARB (rearbitrate on that edge).
- INCR:
  - Grant held while the owner issues SEQ or BUSY.
  - An accepted IDLE or NONSEQ from the owner, or the owner deasserting m_req, ends the burst: go to ARB.
  - A NONSEQ is still forwarded.
- Protocol anomalies inside FIXED:
  - IDLE from the owner: clear the counter and go to ARB.
  - NONSEQ: reload per the new HBURST.

Error handling:
- HRESP=1 with HREADY=0 (first error cycle) clears the counter and forces ARB on the following HREADY=1.
- The owner keeps the grant only if it still requests and wins arbitration.

Data phase:
- On HREADY=1: dp_owner <= current owner index; dp_valid <= (HTRANS is NONSEQ or SEQ) and a grant exists.
- HWDATA = m_hwdata[dp_owner] when dp_valid, else 0.
- HREADY and HRESP are broadcast unchanged to all managers (external wiring).

Grant changes never occur while HREADY=0, so an address phase in flight is never stolen.

Decomposition:
ahb_types_pkg gains:
- htrans_e and hburst_e enums.
- arb_state_e (ARB, FIXED, INCR).
- burst_len() function returning beat count per hburst_e.

Sub-module ahb_rr_picker (combinational round-robin pick from a request vector and last-owner index) keeps the arbiter FSM readable.

Test Plan:
- m_req=4'b0011, both managers issue SINGLE NONSEQ repeatedly, HREADY=1 -> m_grant alternates 0001, 0010, 0001 each transfer; dp_owner follows grant one cycle later.
- Mgr0 INCR4 at HADDR 0x100 with mgr1 requesting throughout -> grant stays 0001 for 4 accepted beats (0x100..0x10C); the grant moves to mgr1 on the edge accepting beat 4.
- Mgr2 WRAP8 with HREADY held 0 for 3 cycles on beat 2 and one BUSY inserted -> counter holds during the stalls and the BUSY; the grant releases only after 8 SEQ/NONSEQ beats.
- Mgr1 INCR burst of 5 beats then IDLE while mgr3 requests -> grant moves to mgr3 the cycle after the IDLE is accepted; HWDATA sources mgr1 for its last data phase.
- HRESP=1 with HREADY=0 on beat 2 of mgr0 INCR8, mgr1 requesting -> FSM returns to ARB; m_grant=0010 after the second error cycle.
- Assert HRESETn=0 mid INCR16 -> m_grant=0, HTRANS=IDLE, dp_valid=0 immediately; after release, first arbitration picks the lowest requester after index 0.
